pmi_addsub_pipe: RTL and testbench

//  Pipelined, parametrised successor of the combinational add/sub primitive: A +/- B +/- carry,

---
 rtl/pmi_addsub_pipe_pkg.sv | 26 ++
 rtl/pmi_addsub_seg.sv | 37 +++
 rtl/pmi_addsub_pipe.sv | 179 +++++++++++++++++
 tb/tb_pmi_addsub_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmi_addsub_pipe_pkg.sv
// Shared definitions for pmi_addsub_pipe: segment geometry helpers and overflow mode.
package pmi_addsub_pipe_pkg;

    typedef enum logic {
        OVF_UNSIGNED = 1'b0,
        OVF_SIGNED   = 1'b1
    } ovf_mode_e;

    function automatic int seg_width(input int w, input int s);
        return (w + s - 1) / s;
    endfunction

    // A trailing segment can start past the top bit when S is close to W; it is then empty.
    function automatic int seg_lo(input int w, input int s, input int k);
        int lo;
        lo = k * seg_width(w, s);
        return (lo > w) ? w : lo;
    endfunction

    function automatic int seg_len(input int w, input int s, input int k);
        int rem;
        rem = w - seg_lo(w, s, k);
        return (rem < seg_width(w, s)) ? rem : seg_width(w, s);
    endfunction

endpackage

// File: rtl/pmi_addsub_seg.sv
// One registered slice of the segmented carry chain: a + b + cin, with the carry into its top bit.
module pmi_addsub_seg #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [width:0] total;
    logic           msb_c;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin};
        msb_c = a[width-1] ^ b[width-1] ^ total[width-1];
    end

    // NOTE: state uses non-blocking assignments so every slice samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            cout    <= 1'b0;
            msb_cin <= 1'b0;
        end else if (en) begin
            sum     <= total[width-1:0];
            cout    <= total[width];
            msb_cin <= msb_c;
        end
    end

endmodule

// File: rtl/pmi_addsub_pipe.sv
// Pipelined A +/- B +/- carry with valid/ready stream handshake and ClkEn gating.
// Optional build macro PMI_ADDSUB_PIPE_SAT_EN clamps Result on overflow.
module pmi_addsub_pipe
    import pmi_addsub_pipe_pkg::*;
#(
    parameter int    pmi_data_width   = 32,
    parameter int    pmi_result_width = 32,
    parameter int    pmi_pipe_stages  = 2,
    parameter string pmi_sign         = "off",
    parameter int    pmi_family       = 0,
    parameter string module_type      = "pmi_addsub_pipe"
) (
    input  logic                        Clock,
    input  logic                        Aclr,
    input  logic                        ClkEn,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [pmi_data_width-1:0]   DataA,
    input  logic [pmi_data_width-1:0]   DataB,
    input  logic                        Cin,
    input  logic                        Add_Sub,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [pmi_result_width-1:0] Result,
    output logic                        Cout,
    output logic                        Overflow
);

    localparam int        data_w = pmi_data_width;
    localparam int        res_w  = pmi_result_width;
    localparam int        stages = pmi_pipe_stages;
    localparam int        last   = stages - 1;
    localparam ovf_mode_e mode   = (pmi_sign == "on") ? OVF_SIGNED : OVF_UNSIGNED;

    logic advance;

    // Stage inputs (*_in) and stage outputs (*_st); stage k feeds stage k+1.
    logic [data_w-1:0] a_in   [stages];
    logic [data_w-1:0] b_in   [stages];
    logic [data_w-1:0] sum_in [stages];
    logic              c_in   [stages];
    logic              cm_in  [stages];
    logic              v_in   [stages];
    logic              add_in [stages];

    logic [data_w-1:0] a_st   [stages];
    logic [data_w-1:0] b_st   [stages];
    logic [data_w-1:0] sum_st [stages];
    logic              c_st   [stages];
    logic              cm_st  [stages];
    logic              v_st   [stages];
    logic              add_st [stages];

    assign advance = ~Aclr & ClkEn & (~OutValid | OutReady);
    assign InReady = advance;

    // Subtraction is A + ~B + Cin, so B is inverted once on entry.
    assign a_in[0]   = DataA;
    assign b_in[0]   = Add_Sub ? DataB : ~DataB;
    assign sum_in[0] = '0;
    assign c_in[0]   = Cin;
    assign cm_in[0]  = 1'b0;
    assign v_in[0]   = InValid;
    assign add_in[0] = Add_Sub;

    for (genvar k = 0; k < stages; k++) begin : g_stage
        localparam int lo  = seg_lo(data_w, stages, k);
        localparam int len = seg_len(data_w, stages, k);

        logic [data_w-1:0] a_q, b_q, hold_q;
        logic              v_q, add_q, cm_q;

        if (k > 0) begin : g_link
            assign a_in[k]   = a_st[k-1];
            assign b_in[k]   = b_st[k-1];
            assign sum_in[k] = sum_st[k-1];
            assign c_in[k]   = c_st[k-1];
            assign cm_in[k]  = cm_st[k-1];
            assign v_in[k]   = v_st[k-1];
            assign add_in[k] = add_st[k-1];
        end

        always_ff @(posedge Clock or posedge Aclr) begin
            if (Aclr) begin
                a_q    <= '0;
                b_q    <= '0;
                hold_q <= '0;
                v_q    <= 1'b0;
                add_q  <= 1'b0;
                cm_q   <= 1'b0;
            end else if (advance) begin
                a_q    <= a_in[k];
                b_q    <= b_in[k];
                hold_q <= sum_in[k];
                v_q    <= v_in[k];
                add_q  <= add_in[k];
                cm_q   <= cm_in[k];
            end
        end

        assign a_st[k]   = a_q;
        assign b_st[k]   = b_q;
        assign v_st[k]   = v_q;
        assign add_st[k] = add_q;

        if (len > 0) begin : g_seg
            localparam logic [data_w-1:0] mask = ({data_w{1'b1}} >> (data_w - len)) << lo;

            logic [len-1:0] seg_sum;
            logic           seg_cout, seg_cm;

            pmi_addsub_seg #(.width(len)) u_seg (
                .clk     (Clock),
                .rst     (Aclr),
                .en      (advance),
                .a       (a_in[k][lo +: len]),
                .b       (b_in[k][lo +: len]),
                .cin     (c_in[k]),
                .sum     (seg_sum),
                .cout    (seg_cout),
                .msb_cin (seg_cm)
            );

            assign sum_st[k] = (hold_q & ~mask) | (data_w'(seg_sum) << lo);
            assign c_st[k]   = seg_cout;
            assign cm_st[k]  = (lo + len == data_w) ? seg_cm : cm_q;
        end else begin : g_empty
            logic c_q;

            always_ff @(posedge Clock or posedge Aclr) begin
                if (Aclr) begin
                    c_q <= 1'b0;
                end else if (advance) begin
                    c_q <= c_in[k];
                end
            end

            assign sum_st[k] = hold_q;
            assign c_st[k]   = c_q;
            assign cm_st[k]  = cm_q;
        end
    end

    logic ovf_raw;

    always_comb begin
        if (mode == OVF_SIGNED) begin
            ovf_raw = cm_st[last] ^ c_st[last];
        end else begin
            ovf_raw = add_st[last] ? c_st[last] : ~c_st[last];
        end
    end

    assign OutValid = v_st[last];
    assign Cout     = c_st[last];
    assign Overflow = OutValid & ovf_raw;

`ifdef PMI_ADDSUB_PIPE_SAT_EN
    logic [data_w-1:0] sat_sum;

    // NOTE: sat_sum gets its wrap value first so every path assigns it and no latch is inferred.
    always_comb begin
        sat_sum = sum_st[last];
        if (Overflow) begin
            if (mode == OVF_SIGNED) begin
                sat_sum = a_st[last][data_w-1] ? {1'b1, {(data_w-1){1'b0}}}
                                               : {1'b0, {(data_w-1){1'b1}}};
            end else begin
                sat_sum = add_st[last] ? {data_w{1'b1}} : {data_w{1'b0}};
            end
        end
    end

    assign Result = sat_sum[res_w-1:0];
`else
    assign Result = sum_st[last][res_w-1:0];
`endif

endmodule

// File: tb/tb_pmi_addsub_pipe.sv
// Scoreboard bench for pmi_addsub_pipe: three configurations share one stimulus stream.
module tb_pmi_addsub_pipe;

    logic        Clock = 1'b0;
    logic        Aclr, ClkEn, InValid, Cin, Add_Sub, OutReady;
    logic [32:0] data_a, data_b;

    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic        co0, co1, co2, of0, of1, of2;
    logic [31:0] res0, res1;
    logic [32:0] res2;

    int checks = 0;
    int errors = 0;
    int acc0   = 0;

    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [35:0] q2[$];

    always #5 Clock = ~Clock;

    pmi_addsub_pipe #(.pmi_data_width(32), .pmi_result_width(32), .pmi_pipe_stages(2),
                      .pmi_sign("off")) u0 (
        .Clock(Clock), .Aclr(Aclr), .ClkEn(ClkEn), .InValid(InValid), .InReady(rdy0),
        .DataA(data_a[31:0]), .DataB(data_b[31:0]), .Cin(Cin), .Add_Sub(Add_Sub),
        .OutValid(ov0), .OutReady(OutReady), .Result(res0), .Cout(co0), .Overflow(of0));

    pmi_addsub_pipe #(.pmi_data_width(32), .pmi_result_width(32), .pmi_pipe_stages(2),
                      .pmi_sign("on")) u1 (
        .Clock(Clock), .Aclr(Aclr), .ClkEn(ClkEn), .InValid(InValid), .InReady(rdy1),
        .DataA(data_a[31:0]), .DataB(data_b[31:0]), .Cin(Cin), .Add_Sub(Add_Sub),
        .OutValid(ov1), .OutReady(OutReady), .Result(res1), .Cout(co1), .Overflow(of1));

    pmi_addsub_pipe #(.pmi_data_width(33), .pmi_result_width(33), .pmi_pipe_stages(4),
                      .pmi_sign("off")) u2 (
        .Clock(Clock), .Aclr(Aclr), .ClkEn(ClkEn), .InValid(InValid), .InReady(rdy2),
        .DataA(data_a), .DataB(data_b), .Cin(Cin), .Add_Sub(Add_Sub),
        .OutValid(ov2), .OutReady(OutReady), .Result(res2), .Cout(co2), .Overflow(of2));

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic, packed as {overflow, cout, result padded to 34 bits}.
    function automatic logic [35:0] model(input logic [32:0] a, input logic [32:0] b,
                                          input logic cin, input logic add,
                                          input int w, input bit sgn);
        logic [34:0] mask, lmask, am, bm, full, low, res;
        logic        co, cm, ovf;
        mask  = (35'd1 << w) - 35'd1;
        lmask = (35'd1 << (w - 1)) - 35'd1;
        am    = {2'b00, a} & mask;
        bm    = (add ? {2'b00, b} : ~{2'b00, b}) & mask;
        full  = am + bm + 35'(cin);
        co    = full[w];
        low   = (am & lmask) + (bm & lmask) + 35'(cin);
        cm    = low[w-1];
        ovf   = sgn ? (cm ^ co) : (add ? co : ~co);
        res   = full & mask;
`ifdef PMI_ADDSUB_PIPE_SAT_EN
        if (ovf) begin
            if (sgn) res = a[w-1] ? (35'd1 << (w - 1)) : lmask;
            else     res = add ? mask : 35'd0;
        end
`endif
        return {ovf, co, res[33:0]};
    endfunction

    always @(negedge Clock) begin
        if (Aclr) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            if (InValid && rdy0) begin
                q0.push_back(model(data_a, data_b, Cin, Add_Sub, 32, 1'b0));
                acc0++;
            end
            if (InValid && rdy1) q1.push_back(model(data_a, data_b, Cin, Add_Sub, 32, 1'b1));
            if (InValid && rdy2) q2.push_back(model(data_a, data_b, Cin, Add_Sub, 33, 1'b0));
            if (ov0 && OutReady && ClkEn) begin
                check("u0_expected_beat", 36'(q0.size() != 0), 36'd1);
                if (q0.size() != 0) check("u0_result", {of0, co0, 2'b00, res0}, q0.pop_front());
            end
            if (ov1 && OutReady && ClkEn) begin
                check("u1_expected_beat", 36'(q1.size() != 0), 36'd1);
                if (q1.size() != 0) check("u1_result", {of1, co1, 2'b00, res1}, q1.pop_front());
            end
            if (ov2 && OutReady && ClkEn) begin
                check("u2_expected_beat", 36'(q2.size() != 0), 36'd1);
                if (q2.size() != 0) check("u2_result", {of2, co2, 1'b0, res2}, q2.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Launch one beat and report, per pipe, the cycle count to OutValid and the outputs seen there.
    task automatic send_one(input logic [32:0] a, input logic [32:0] b, input logic cin,
                            input logic add, output int lat0, output int lat2,
                            output logic [35:0] o0, output logic [35:0] o1, output logic [35:0] o2);
        data_a  = a;
        data_b  = b;
        Cin     = cin;
        Add_Sub = add;
        InValid = 1'b1;
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        lat0 = 0;
        lat2 = 0;
        o0 = '0;
        o1 = '0;
        o2 = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            if (ov0 && lat0 == 0) begin
                lat0 = c;
                o0   = {of0, co0, 2'b00, res0};
                o1   = {of1, co1, 2'b00, res1};
            end
            if (ov2 && lat2 == 0) begin
                lat2 = c;
                o2   = {of2, co2, 1'b0, res2};
            end
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat0, lat2, acc_b, out_b, start, cycles;
        logic        seen;
        logic [35:0] o0, o1, o2;
        logic [63:0] r;

        Aclr = 1'b1; ClkEn = 1'b0; InValid = 1'b0; Cin = 1'b0; Add_Sub = 1'b1;
        OutReady = 1'b0; data_a = '0; data_b = '0;
        step();
        step();
        ClkEn = 1'b1;
        OutReady = 1'b1;
        #1;
        check("reset_u0_outputs", {ov0, co0, of0, 1'b0, res0}, 36'd0);
        check("reset_u2_outputs", {ov2, co2, of2, res2}, 36'd0);
        check("reset_inready_low", {33'd0, rdy0, rdy1, rdy2}, 36'd0);
        step();
        Aclr = 1'b0;
        #1;
        check("inready_after_release", {33'd0, rdy0, rdy1, rdy2}, 36'h7);
        step();

        send_one(33'h0_FFFF_FFFF, 33'd1, 1'b0, 1'b1, lat0, lat2, o0, o1, o2);
        check("add_wrap_latency_s2", 36'(lat0), 36'd2);
`ifdef PMI_ADDSUB_PIPE_SAT_EN
        check("add_wrap_unsigned", o0, {1'b1, 1'b1, 2'b00, 32'hFFFF_FFFF});
`else
        check("add_wrap_unsigned", o0, {1'b1, 1'b1, 2'b00, 32'h0000_0000});
`endif

        send_one(33'h0_7FFF_FFFF, 33'd1, 1'b0, 1'b1, lat0, lat2, o0, o1, o2);
`ifdef PMI_ADDSUB_PIPE_SAT_EN
        check("add_signed_overflow", o1, {1'b1, 1'b0, 2'b00, 32'h7FFF_FFFF});
`else
        check("add_signed_overflow", o1, {1'b1, 1'b0, 2'b00, 32'h8000_0000});
`endif

        send_one(33'd5, 33'd7, 1'b1, 1'b0, lat0, lat2, o0, o1, o2);
`ifdef PMI_ADDSUB_PIPE_SAT_EN
        check("sub_borrow_unsigned", o0, {1'b1, 1'b0, 2'b00, 32'h0000_0000});
`else
        check("sub_borrow_unsigned", o0, {1'b1, 1'b0, 2'b00, 32'hFFFF_FFFE});
`endif

        send_one(33'h1_FFFF_FFFF, 33'd1, 1'b0, 1'b1, lat0, lat2, o0, o1, o2);
        check("uneven_seg_latency_s4", 36'(lat2), 36'd4);
`ifdef PMI_ADDSUB_PIPE_SAT_EN
        check("uneven_seg_ripple", o2, {1'b1, 1'b1, 1'b0, 33'h1_FFFF_FFFF});
`else
        check("uneven_seg_ripple", o2, {1'b1, 1'b1, 1'b0, 33'h0_0000_0000});
`endif

        // Stall: the output beat must hold while OutReady is low and while ClkEn is low.
        OutReady = 1'b0;
        data_a = 33'd3; data_b = 33'd4; Cin = 1'b0; Add_Sub = 1'b1; InValid = 1'b1;
        step();
        InValid = 1'b0;
        repeat (4) step();
        check("stall_hold_result", {1'b0, ov0, rdy0, 1'b0, res0}, {4'b0100, 32'd7});
        OutReady = 1'b1;
        ClkEn = 1'b0;
        repeat (3) step();
        check("clken_freeze", {1'b0, ov0, rdy0, 1'b0, res0}, {4'b0100, 32'd7});
        ClkEn = 1'b1;
        repeat (6) step();

        // Back-to-back burst: one beat per cycle in and out.
        acc_b = 0;
        out_b = 0;
        for (int i = 0; i < 8; i++) begin
            data_a = 33'(i * 32'h1357_9BDF); data_b = 33'(i * 32'h0F0F_1234);
            Cin = i[0]; Add_Sub = i[1]; InValid = 1'b1;
            @(negedge Clock);
            if (rdy0) acc_b++;
            if (ov0) out_b++;
            step();
        end
        InValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (ov0) out_b++;
            step();
        end
        check("burst_accepts", 36'(acc_b), 36'd8);
        check("burst_outputs", 36'(out_b), 36'd8);

        // Random stream with OutReady and ClkEn toggling.
        start = acc0;
        cycles = 0;
        while (acc0 - start < 100 && cycles < 5000) begin
            r = {$urandom(), $urandom()};
            data_a = r[32:0];
            r = {$urandom(), $urandom()};
            data_b = r[32:0];
            Cin      = 1'($urandom_range(0, 1));
            Add_Sub  = 1'($urandom_range(0, 1));
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = 1'($urandom_range(0, 1));
            ClkEn    = ($urandom_range(0, 3) != 0);
            step();
            cycles++;
        end
        check("stream_100_beats", 36'(acc0 - start >= 100), 36'd1);
        InValid = 1'b0;
        OutReady = 1'b1;
        ClkEn = 1'b1;
        repeat (10) step();
        check("stream_drained", 36'(q0.size() + q1.size() + q2.size()), 36'd0);

        // Aclr with two beats in flight: nothing stale may ever come out.
        data_a = 33'd100; data_b = 33'd1; Add_Sub = 1'b1; InValid = 1'b1;
        step();
        data_a = 33'd200;
        step();
        InValid = 1'b0;
        Aclr = 1'b1;
        #1;
        check("aclr_kills_outvalid", {33'd0, ov0, ov1, ov2}, 36'd0);
        step();
        Aclr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (ov0 || ov1 || ov2) seen = 1'b1;
            step();
        end
        check("no_stale_after_aclr", 36'(seen), 36'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
